// File: rtl/shift_reg_universal_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_universal_if
// Description : Control, data and status bundle for the universal shift
//               register. The master drives mode/load/burst controls and
//               observes the register taps and burst status.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_reg_universal_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_in_msb;
  logic             serial_in_lsb;
  logic             start;
  logic [CW-1:0]    shift_count;
  logic             shift_dir;
  logic [WIDTH-1:0] parallel_out;
  logic             serial_out_msb;
  logic             serial_out_lsb;
  logic             busy;
  logic             done;

  modport master (
    output enable, mode, parallel_in, serial_in_msb, serial_in_lsb,
           start, shift_count, shift_dir,
    input  parallel_out, serial_out_msb, serial_out_lsb, busy, done
  );

  modport slave (
    input  enable, mode, parallel_in, serial_in_msb, serial_in_lsb,
           start, shift_count, shift_dir,
    output parallel_out, serial_out_msb, serial_out_lsb, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/shift_reg_universal.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_universal
// Description : Parametrised universal shift register with hold, shift
//               right/left and parallel load, plus a counted burst-shift
//               engine reporting busy and a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_universal #(
  parameter int WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  shift_reg_universal_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_width = CW'(WIDTH);
  localparam logic [CW-1:0] c_one   = CW'(1);

  localparam logic [1:0] c_mode_hold  = 2'b00;
  localparam logic [1:0] c_mode_right = 2'b01;
  localparam logic [1:0] c_mode_left  = 2'b10;
  localparam logic [1:0] c_mode_load  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_remaining;
  logic             r_dir;
  logic             r_done;

  state_t           w_next_state;
  logic [WIDTH-1:0] w_next_data;
  logic [CW-1:0]    w_next_remaining;
  logic             w_next_dir;
  logic             w_next_done;

  logic [WIDTH-1:0] w_shift_right;
  logic [WIDTH-1:0] w_shift_left;
  logic [CW-1:0]    w_count_sat;

  // Shift candidates always use the live fill bits, in IDLE and in BURST
  assign w_shift_right = {bus.serial_in_msb, r_data[WIDTH-1:1]};
  assign w_shift_left  = {r_data[WIDTH-2:0], bus.serial_in_lsb};
  // Requests longer than the register clamp to a full-width shift
  assign w_count_sat   = (bus.shift_count > c_width) ? c_width : bus.shift_count;

  // Next-state logic: start beats mode in IDLE, a stalled burst holds everything
  always_comb begin
    w_next_state     = r_state;
    w_next_data      = r_data;
    w_next_remaining = r_remaining;
    w_next_dir       = r_dir;
    w_next_done      = 1'b0;

    if (bus.enable) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            w_next_dir       = bus.shift_dir;
            w_next_remaining = w_count_sat;
            if (w_count_sat == '0) begin
              w_next_done = 1'b1;
            end else begin
              w_next_state = ST_BURST;
            end
          end else begin
            case (bus.mode)
              c_mode_hold:  w_next_data = r_data;
              c_mode_right: w_next_data = w_shift_right;
              c_mode_left:  w_next_data = w_shift_left;
              c_mode_load:  w_next_data = bus.parallel_in;
              default:      w_next_data = r_data;
            endcase
          end
        end
        ST_BURST: begin
          w_next_data      = r_dir ? w_shift_left : w_shift_right;
          w_next_remaining = r_remaining - c_one;
          if (r_remaining == c_one) begin
            w_next_state = ST_IDLE;
            w_next_done  = 1'b1;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // State register; reset overrides enable and aborts any burst silently
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_remaining <= '0;
      r_dir       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_data      <= w_next_data;
      r_remaining <= w_next_remaining;
      r_dir       <= w_next_dir;
      r_done      <= w_next_done;
    end
  end

  assign bus.parallel_out   = r_data;
  assign bus.serial_out_msb = r_data[WIDTH-1];
  assign bus.serial_out_lsb = r_data[0];
  assign bus.busy           = (r_state == ST_BURST);
  assign bus.done           = r_done;

endmodule
`default_nettype wire

// File: doc/shift_reg_universal.md
# shift_reg_universal

Parametrised universal shift register, the successor to the fixed 4-bit parallel-in/parallel-out register. Per-cycle modes are hold, shift right, shift left and parallel load, with serial fill and serial taps at both ends. A counted burst-shift engine performs N shifts autonomously and reports busy/done. It sits between parallel datapaths and serial links as loader, serialiser or deserialiser.

## Interface
- WIDTH, default 8, register width in bits; legal values are WIDTH >= 2.
- CW, default $clog2(WIDTH+1), width of the shift-count port; derived, not overridden.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset; sampled only on the rising edge of clock.
- enable  in  1  clock enable; when low, all state holds, including burst progress.
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load; used only in IDLE.
- parallel_in  in  WIDTH  load data for mode 11.
- serial_in_msb  in  1  fill bit entering bit WIDTH-1 on a right shift.
- serial_in_lsb  in  1  fill bit entering bit 0 on a left shift.
- start  in  1  burst request; sampled in IDLE with enable=1.
- shift_count  in  CW  number of burst shifts; values > WIDTH saturate to WIDTH.
- shift_dir  in  1  burst direction: 0 right, 1 left.
- parallel_out  out  WIDTH  register contents.
- serial_out_msb  out  1  equals parallel_out[WIDTH-1].
- serial_out_lsb  out  1  equals parallel_out[0].
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse when a burst completes.

## Operation
- Shift right: reg <= {serial_in_msb, reg[WIDTH-1:1]}.
- Shift left: reg <= {reg[WIDTH-2:0], serial_in_lsb}.
- Parallel load: reg <= parallel_in.
- Hold: reg unchanged.
- FSM has two states, IDLE and BURST. Reset state is IDLE.
- IDLE, enable=1, start=0: apply mode.
- IDLE, enable=1, start=1: start takes priority and mode is ignored that cycle; reg holds.
  - Latch the direction and the saturated count into the remaining-count register.
  - Count 0: stay in IDLE and pulse done; no shift occurs.
  - Count >= 1: go to BURST.
- BURST, enable=1: shift one bit in the latched direction, using the live serial_in_* for fill, and decrement remaining.
  - When a shift brings remaining to 0, return to IDLE and pulse done.
- BURST, enable=0: stall; reg, remaining and state all hold, and done stays 0.
- In BURST, mode, start, shift_count and shift_dir are ignored. A start asserted on the same edge that completes a burst is ignored; a new burst needs start sampled in IDLE.
- serial_out_* are combinational taps of the register, with no added delay.

## Timing
- Reset values: parallel_out = 0, serial_out_msb = 0, serial_out_lsb = 0, busy = 0, done = 0, state IDLE, remaining = 0.
- Reset has priority over enable and over all other inputs.
- Reset asserted mid-burst aborts the burst, clears the register, and produces no done pulse.
- Mode operations: the result is visible on parallel_out one cycle after the sampling edge.
- Burst: start is sampled at edge k.
  - Count N >= 1, enable held high: shifts happen at edges k+1 .. k+N.
  - busy = 1 during the N cycles after edges k .. k+N-1, and 0 after edge k+N.
  - done = 1 for exactly the cycle after edge k+N.
  - Each enable=0 cycle extends the burst by one cycle.
  - Count 0: done = 1 in the cycle after edge k; busy stays 0.
- done and busy are registered outputs and are never high together.

## Test plan
- Reset, then parallel load: assert reset for 2 edges, then set mode=11, parallel_in=0xA5 (WIDTH=8) -> parallel_out=0x00 while in reset; parallel_out=0xA5 one cycle after the load edge; serial_out_msb=1, serial_out_lsb=1.
- Per-cycle shifting: from 0xA5, shift right with serial_in_msb=1 -> 0xD2; then shift left with serial_in_lsb=0 -> 0xA4; then mode=00 for 3 cycles -> 0xA4 is held.
- Burst: from 0x81, start with shift_count=3, shift_dir=1, serial_in_lsb=0 -> busy high for 3 cycles, parallel_out=0x08, done pulses for 1 cycle after busy falls; mode=11 toggled during the burst has no effect.
- Stall and saturation: burst with shift_count=15, shift_dir=0, serial_in_msb=1, with enable low for 2 cycles mid-burst -> exactly 8 shifts, busy high for 10 cycles, final value 0xFF.
- Boundary cases: start with shift_count=0 -> done pulse next cycle, busy=0, register unchanged. Start and mode=11 on the same edge -> no load occurs.
- Reset mid-burst: assert reset 2 cycles into a 5-shift burst -> parallel_out=0, busy=0, and no done pulse. A new burst after reset operates normally.
